// File: rtl/image_load_scheduler.sv
// -----------------------------------------------------------------------------
// image_load_scheduler
//   Sequences a host image upload into the frame buffer. Pixels arriving from
//   the UART loader (no backpressure) are buffered in a small show-ahead FIFO
//   and written out as linear-address requests over a valid/ready write port.
//   One full frame (H_ACT*V_ACT pixels) is counted. Status flags let the
//   display/camera path stay off the buffer while a frame is loading.
//
// Ports
//   clk_clk        in   single clock
//   reset_reset_n  in   synchronous reset, active low
//   i_start        in   pulse: start loading a frame (only honoured in IDLE)
//   i_abort        in   pulse: cancel the load and flush the FIFO
//   i_pix_data     in   RGB888 pixel
//   i_pix_valid    in   i_pix_data valid this cycle
//   o_wr_addr      out  frame-buffer write address
//   o_wr_data      out  pixel to write (FIFO head)
//   o_wr_valid     out  write request pending
//   i_wr_ready     in   write accepted when o_wr_valid && i_wr_ready
//   o_busy         out  high while loading or draining
//   o_done         out  one-cycle pulse when the whole frame is written
//   o_overflow     out  sticky: a pixel was dropped on a full FIFO
//   o_pix_cnt      out  pixels accepted in the current frame
// -----------------------------------------------------------------------------
module image_load_scheduler #(
  parameter int          H_ACT      = 640,
  parameter int          V_ACT      = 480,
  parameter int          ADDR_W     = 23,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [23:0]       i_pix_data,
  input  logic              i_pix_valid,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [23:0]       o_wr_data,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  output logic [19:0]       o_pix_cnt
);

  localparam int                PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [19:0]       FRAME_PIX = 20'(H_ACT * V_ACT);
  localparam logic [ADDR_W-1:0] BASE_C    = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [23:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [19:0]       pix_cnt_q;
  logic              ovf_q;
  logic              done_q;

  logic active, fifo_empty, fifo_full, wr_valid;
  logic take, push, pop, drop, last_pix, abort;

  always_comb begin
    active     = (state_q == S_LOAD) || (state_q == S_DRAIN);
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == DEPTH_C);
    wr_valid   = !fifo_empty && active;
    pop        = wr_valid && i_wr_ready;
    // Every pixel seen in LOAD counts toward the frame, even if it is dropped,
    // so the frame length stays aligned with the loader.
    take       = (state_q == S_LOAD) && i_pix_valid;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    push       = take && (!fifo_full || pop);
    drop       = take && fifo_full && !pop;
    last_pix   = take && (pix_cnt_q == FRAME_PIX - 20'd1);
    abort      = i_abort && (state_q != S_IDLE);
  end

  // Pixel storage carries data only; it needs no reset.
  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_pix_data;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      addr_q    <= BASE_C;
      pix_cnt_q <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // A completed handshake is honoured even in the cycle an abort lands.
      if (pop) begin
        addr_q <= addr_q + 1'b1;
      end

      if (abort) begin
        // Abort beats start and frame completion; counters keep their values.
        state_q  <= S_IDLE;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (active) begin
          if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
          end
          if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
          end
          if (push && !pop) begin
            cnt_q <= cnt_q + 1'b1;
          end else if (pop && !push) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        case (state_q)
          S_IDLE: begin
            if (i_start) begin
              state_q   <= S_LOAD;
              pix_cnt_q <= '0;
              ovf_q     <= 1'b0;
              addr_q    <= BASE_C;
              wr_ptr_q  <= '0;
              rd_ptr_q  <= '0;
              cnt_q     <= '0;
            end
          end
          S_LOAD: begin
            if (take) begin
              pix_cnt_q <= pix_cnt_q + 20'd1;
            end
            if (drop) begin
              ovf_q <= 1'b1;
            end
            if (last_pix) begin
              state_q <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            // Empty FIFO means no request is outstanding on the write port.
            if (fifo_empty) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_wr_valid = wr_valid;
  // Gate the head so an idle or freshly reset port presents zero data.
  assign o_wr_data  = wr_valid ? mem_q[rd_ptr_q] : 24'd0;
  assign o_wr_addr  = addr_q;
  assign o_busy     = active;
  assign o_done     = done_q;
  assign o_overflow = ovf_q;
  assign o_pix_cnt  = pix_cnt_q;

endmodule

// File: tb/tb_image_load_scheduler.sv
module tb_image_load_scheduler;

  localparam int ADDR_W = 23;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic              i_start;
  logic              i_abort;
  logic [23:0]       i_pix_data;
  logic              i_pix_valid;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [23:0]       o_wr_data;
  logic              o_wr_valid;
  logic              i_wr_ready;
  logic              o_busy;
  logic              o_done;
  logic              o_overflow;
  logic [19:0]       o_pix_cnt;

  image_load_scheduler #(
    .H_ACT(4), .V_ACT(2), .ADDR_W(ADDR_W), .BASE_ADDR(32'h100), .FIFO_DEPTH(4)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .i_start(i_start), .i_abort(i_abort),
    .i_pix_data(i_pix_data), .i_pix_valid(i_pix_valid),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_valid(o_wr_valid),
    .i_wr_ready(i_wr_ready), .o_busy(o_busy), .o_done(o_done),
    .o_overflow(o_overflow), .o_pix_cnt(o_pix_cnt)
  );

  always #5 clk_clk = ~clk_clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Accepted writes and done pulses, sampled mid-cycle where inputs are stable.
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          done_cnt = 0;

  always @(negedge clk_clk) begin
    if (reset_reset_n && o_wr_valid && i_wr_ready) begin
      wa_q.push_back(32'(o_wr_addr));
      wd_q.push_back(32'(o_wr_data));
    end
    if (o_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_pix(input logic [23:0] d);
    i_pix_valid = 1'b1;
    i_pix_data  = d;
    tick();
    i_pix_valid = 1'b0;
  endtask

  int wbase;
  int dbase;

  initial begin
    reset_reset_n = 1'b0;
    i_start = 1'b0; i_abort = 1'b0; i_pix_data = '0; i_pix_valid = 1'b0; i_wr_ready = 1'b0;

    // 1: reset with random inputs
    for (int i = 0; i < 2; i++) begin
      i_start     = 1'($urandom);
      i_abort     = 1'($urandom);
      i_pix_valid = 1'($urandom);
      i_pix_data  = 24'($urandom);
      i_wr_ready  = 1'($urandom);
      tick();
    end
    i_start = 1'b0; i_abort = 1'b0; i_pix_valid = 1'b0; i_pix_data = '0; i_wr_ready = 1'b0;
    chk("rst_addr",  32'(o_wr_addr),  32'h100);
    chk("rst_valid", 32'(o_wr_valid), 32'd0);
    chk("rst_data",  32'(o_wr_data),  32'd0);
    chk("rst_busy",  32'(o_busy),     32'd0);
    chk("rst_done",  32'(o_done),     32'd0);
    chk("rst_ovf",   32'(o_overflow), 32'd0);
    chk("rst_cnt",   32'(o_pix_cnt),  32'd0);
    reset_reset_n = 1'b1;
    tick();

    // 2: basic frame with ready held high
    i_wr_ready = 1'b1;
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("f_busy", 32'(o_busy), 32'd1);
    wbase = wa_q.size();
    dbase = done_cnt;
    push_pix(24'd1);
    chk("f_lat_valid", 32'(o_wr_valid), 32'd1);
    chk("f_lat_data",  32'(o_wr_data),  32'd1);
    for (int k = 2; k <= 8; k++) push_pix(24'(k));
    tick();
    chk("f_drain_valid", 32'(o_wr_valid), 32'd0);
    chk("f_drain_done",  32'(o_done),     32'd0);
    tick();
    chk("f_done",      32'(o_done), 32'd1);
    chk("f_done_busy", 32'(o_busy), 32'd0);
    tick();
    chk("f_done_pulse", 32'(o_done), 32'd0);
    chk("f_nwr", 32'(wa_q.size() - wbase), 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk("f_addr", wa_q[wbase+k], 32'h100 + 32'(k));
      chk("f_data", wd_q[wbase+k], 32'(k + 1));
    end
    chk("f_cnt",   32'(o_pix_cnt),  32'd8);
    chk("f_ovf",   32'(o_overflow), 32'd0);
    chk("f_ndone", 32'(done_cnt - dbase), 32'd1);

    // 3: backpressure and overflow
    i_wr_ready = 1'b0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    wbase = wa_q.size();
    for (int k = 1; k <= 5; k++) begin
      push_pix(24'(k));
      if (k == 4) chk("bp_ovf4", 32'(o_overflow), 32'd0);
    end
    chk("bp_ovf",   32'(o_overflow), 32'd1);
    chk("bp_cnt",   32'(o_pix_cnt),  32'd5);
    chk("bp_valid", 32'(o_wr_valid), 32'd1);
    chk("bp_head",  32'(o_wr_data),  32'd1);
    chk("bp_addr",  32'(o_wr_addr),  32'h100);
    chk("bp_nowr",  32'(wa_q.size() - wbase), 32'd0);
    i_wr_ready = 1'b1;
    repeat (4) tick();
    chk("bp_empty", 32'(o_wr_valid), 32'd0);
    dbase = done_cnt;
    for (int k = 6; k <= 8; k++) push_pix(24'(k));
    tick();
    tick();
    chk("bp_done", 32'(o_done), 32'd1);
    chk("bp_nwr", 32'(wa_q.size() - wbase), 32'd7);
    for (int k = 0; k < 4; k++) begin
      chk("bp_addr_k", wa_q[wbase+k], 32'h100 + 32'(k));
      chk("bp_data_k", wd_q[wbase+k], 32'(k + 1));
    end
    for (int k = 4; k < 7; k++) begin
      chk("bp_addr_t", wa_q[wbase+k], 32'h100 + 32'(k));
      chk("bp_data_t", wd_q[wbase+k], 32'(k + 2));
    end
    tick();
    chk("bp_ovf_sticky", 32'(o_overflow), 32'd1);
    chk("bp_cnt_end",    32'(o_pix_cnt),  32'd8);

    // 4: abort with pixels queued
    i_wr_ready = 1'b0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("ab_ovf_clr", 32'(o_overflow), 32'd0);
    chk("ab_cnt_clr", 32'(o_pix_cnt),  32'd0);
    for (int k = 1; k <= 3; k++) push_pix(24'(k));
    dbase = done_cnt;
    i_abort = 1'b1; tick(); i_abort = 1'b0;
    chk("ab_busy",  32'(o_busy),     32'd0);
    chk("ab_valid", 32'(o_wr_valid), 32'd0);
    chk("ab_cnt",   32'(o_pix_cnt),  32'd3);
    tick(); tick();
    chk("ab_nodone", 32'(done_cnt - dbase), 32'd0);
    i_wr_ready = 1'b1;
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("ab_re_cnt",   32'(o_pix_cnt),  32'd0);
    chk("ab_re_addr",  32'(o_wr_addr),  32'h100);
    chk("ab_re_valid", 32'(o_wr_valid), 32'd0);
    push_pix(24'h00000A);
    chk("ab_re_data", 32'(o_wr_data), 32'h00000A);
    chk("ab_re_wa",   32'(o_wr_addr), 32'h100);
    i_abort = 1'b1; tick(); i_abort = 1'b0;

    // 5: ignored inputs
    wbase = wa_q.size();
    i_pix_valid = 1'b1; i_pix_data = 24'h123456;
    repeat (3) tick();
    i_pix_valid = 1'b0;
    chk("ig_nowr",  32'(wa_q.size() - wbase), 32'd0);
    chk("ig_valid", 32'(o_wr_valid), 32'd0);
    chk("ig_cnt",   32'(o_pix_cnt),  32'd1);
    i_start = 1'b1; tick(); i_start = 1'b0;
    push_pix(24'd1);
    push_pix(24'd2);
    i_start = 1'b1; push_pix(24'd3); i_start = 1'b0;
    chk("ig_start_cnt",  32'(o_pix_cnt), 32'd3);
    chk("ig_start_busy", 32'(o_busy),    32'd1);
    for (int k = 4; k <= 7; k++) push_pix(24'(k));
    dbase = done_cnt;
    i_abort = 1'b1; push_pix(24'd8); i_abort = 1'b0;
    chk("ig_ab_busy",  32'(o_busy),     32'd0);
    chk("ig_ab_valid", 32'(o_wr_valid), 32'd0);
    chk("ig_ab_cnt",   32'(o_pix_cnt),  32'd7);
    tick(); tick();
    chk("ig_ab_nodone", 32'(done_cnt - dbase), 32'd0);

    // 6: reset during DRAIN with a write pending
    i_wr_ready = 1'b0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    for (int k = 1; k <= 8; k++) push_pix(24'(k));
    chk("rd_busy",  32'(o_busy),     32'd1);
    chk("rd_valid", 32'(o_wr_valid), 32'd1);
    chk("rd_cnt",   32'(o_pix_cnt),  32'd8);
    reset_reset_n = 1'b0; tick();
    chk("rd_r_valid", 32'(o_wr_valid), 32'd0);
    chk("rd_r_busy",  32'(o_busy),     32'd0);
    chk("rd_r_cnt",   32'(o_pix_cnt),  32'd0);
    chk("rd_r_ovf",   32'(o_overflow), 32'd0);
    chk("rd_r_addr",  32'(o_wr_addr),  32'h100);
    reset_reset_n = 1'b1;
    i_wr_ready = 1'b1;
    wbase = wa_q.size();
    tick(); tick();
    chk("rd_idle_valid", 32'(o_wr_valid), 32'd0);
    chk("rd_idle_nowr",  32'(wa_q.size() - wbase), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
